// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to let fetch win after four consecutive contended data grants.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      state, state_nx;
    logic        owner, arb, guard, grant_d, grant_f;
    logic [3:0]  lat_we;
    logic [31:0] lat_addr, lat_wdata, if_rdata_q, d_rdata_q;
    assign arb = state != ISSUE;
`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] d_run;
    assign guard = d_run == 3'd4 && if_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            d_run <= '0;
        else if (arb)
            d_run <= grant_d && if_req ? d_run + 3'd1 : '0;
    end
`else
    assign guard = 1'b0;
`endif
    assign grant_d = arb && d_req && !guard;
    assign grant_f = arb && if_req && !grant_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == ISSUE ? RESP : (grant_d || grant_f) ? ISSUE : IDLE;
    end
    // Latched request and per-requester held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            lat_addr   <= '0;
            lat_we     <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_d || grant_f) begin
                owner     <= grant_d;
                lat_addr  <= grant_d ? d_addr : if_addr;
                lat_we    <= grant_d ? d_we : '0;
                lat_wdata <= grant_d ? d_wdata : '0;
            end
            if (state == RESP && !owner)
                if_rdata_q <= mem_rdata;
            if (state == RESP && owner && lat_we == '0)
                d_rdata_q <= mem_rdata;
        end
    end
    always_comb begin
        mem_en    = state == ISSUE;
        mem_we    = mem_en ? lat_we : '0;
        mem_addr  = mem_en ? lat_addr : '0;
        mem_wdata = mem_en ? lat_wdata : '0;
        if_valid  = state == RESP && !owner;
        d_valid   = state == RESP && owner;
        if_rdata  = if_valid ? mem_rdata : if_rdata_q;
        d_rdata   = d_valid && lat_we == '0 ? mem_rdata : d_rdata_q;
        if_stall  = if_req && !if_valid;
        d_stall   = d_req && !d_valid;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports if_req (in, 1) and if_addr (in, 32): instruction-fetch read request and word address.
REQ-004 SHALL have ports if_valid (out, 1) and if_rdata (out, 32): fetch completion pulse and read data.
REQ-005 SHALL have ports d_req (in, 1), d_addr (in, 32), d_we (in, 4) and d_wdata (in, 32): data request, address, byte write enables and write data.
REQ-006 SHALL have ports d_valid (out, 1) and d_rdata (out, 32): data completion pulse and read data.
REQ-007 SHALL have ports if_stall (out, 1) and d_stall (out, 1): pipeline stall indicators.
REQ-008 SHALL have ports mem_en (out, 1), mem_we (out, 4), mem_addr (out, 32), mem_wdata (out, 32) and mem_rdata (in, 32): single shared memory port with synchronous 1-cycle read.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE and RESP, plus a 1-bit owner register (0 = fetch, 1 = data).
REQ-010 SHALL arbitrate in IDLE and RESP as follows: if d_req, grant data (subject to REQ-019); else if if_req, grant fetch; else go to IDLE.
REQ-011 SHALL, on grant, latch address, we and wdata (we = 0 and wdata = 0 for fetch) and set owner; the next state is ISSUE.
REQ-012 SHALL, in ISSUE, drive mem_en = 1 and drive mem_we, mem_addr and mem_wdata from the latched values; the next state is RESP.
REQ-013 SHALL drive mem_en = 0, mem_we = 0, mem_addr = 0 and mem_wdata = 0 in IDLE and RESP.
REQ-014 SHALL, in RESP, pulse the owner's valid for exactly 1 cycle.
REQ-015 SHALL drive xx_rdata = mem_rdata for the owner during RESP, and then hold that value in a per-requester register until that requester's next RESP.
REQ-016 SHALL complete writes (d_we != 0) with d_valid but leave d_rdata unchanged.
REQ-017 SHALL fix latency: req sampled at edge N, mem_en high in cycle N+1, valid in cycle N+2; back-to-back throughput is 1 access per 2 cycles.
REQ-018 SHALL obey these handshake rules:
- the requester holds req, addr, we and wdata stable until its valid;
- req high in the same cycle as its own valid counts as a new request using the values presented in that cycle;
- if_stall = if_req & ~if_valid, and d_stall = d_req & ~d_valid (combinational).
REQ-019 SHALL treat simultaneous if_req and d_req as a data win, except as overridden by REQ-024.
REQ-020 SHALL not preempt an access: requests arriving during ISSUE wait for arbitration in RESP.

Reset
REQ-021 SHALL, on rst_n low, immediately set state to IDLE, owner to 0, latched registers to 0, held rdata registers to 0 and the run counter to 0; all outputs are then 0, except stall outputs, which follow REQ-018.
REQ-022 SHALL, on reset mid-ISSUE or mid-RESP, abort the in-flight access and produce no valid pulse after rst_n deasserts.
REQ-023 SHALL sample requests at the first rising edge after rst_n goes high.

Configuration
REQ-024 SHALL, with macro ARB_STARVE_GUARD_EN defined, use a 3-bit counter d_run:
- d_run increments on each data grant made while if_req = 1;
- d_run clears on a fetch grant or when if_req = 0 at an arbitration point;
- when d_run = 4 and if_req = 1, fetch wins over d_req.
REQ-025 SHALL, with ARB_STARVE_GUARD_EN undefined, exclude the counter and use strict data priority; fetch can then starve indefinitely.

Verification
REQ-026 SHALL cover: single fetch with if_req = 1 and if_addr = 0x100, mem_rdata = 0xDEADBEEF in RESP -> mem_en in cycle 1 with mem_addr = 0x100, if_valid in cycle 2, if_rdata = 0xDEADBEEF held afterwards.
REQ-027 SHALL cover: simultaneous if_req and d_req with d_addr = 0x200 and d_we = 0 -> data is served first (d_valid in cycle 2), fetch issues in cycle 3 and if_valid occurs in cycle 4; if_stall is high in cycles 0-3.
REQ-028 SHALL cover: store with d_we = 0xF, d_addr = 0x40 and d_wdata = 0x12345678 -> mem_we = 0xF and mem_wdata = 0x12345678 in ISSUE, d_valid pulses, d_rdata unchanged.
REQ-029 SHALL cover: d_req held high for 12 cycles with if_req high -> with the macro, fetch is granted after the 4th data grant; without the macro, no if_valid occurs until d_req drops.
REQ-030 SHALL cover: rst_n pulled low during ISSUE of a data access -> all outputs become 0 asynchronously, no d_valid after release, and a new request completes with the normal 2-cycle latency.
REQ-031 SHALL cover: fetch req kept high across its if_valid with if_addr changed from 0x0 to 0x4 in the valid cycle -> the second access uses mem_addr = 0x4, issued in the cycle after RESP.
